// File: rtl/ca_replica_nco.sv
// C/A replica generator driven by a code-rate NCO.
// Phase = chip_index + fractional chip; NUM_TAPS replica taps are read from
// the PRN table at sub-chip offsets around the prompt position. Phase is moved
// by load (absolute) and slew (relative, one sub-chip per enabled cycle)
// commands over a valid/ready handshake.

// One replica tap: wraps (P + OFFSET) into the code period and picks the chip.
module ca_replica_tap #(
    parameter int SUBCHIP_BITS = 2,
    parameter int OFFSET       = 0
) (
    input  logic [9:0]              chip,
    input  logic [SUBCHIP_BITS-1:0] sub,
    input  logic [1022:0]           code,
    output logic                    tap_bit
);
    localparam int MOD = 1023 << SUBCHIP_BITS;

    logic signed [31:0] pos_s;

    // Offset position folded back into [0, MOD) so taps wrap in both directions.
    always_comb begin
        pos_s = $signed({{(22 - SUBCHIP_BITS){1'b0}}, chip, sub}) + OFFSET;
        if (pos_s < 0)
            pos_s = pos_s + MOD;
        else if (pos_s >= MOD)
            pos_s = pos_s - MOD;
        tap_bit = code[pos_s[SUBCHIP_BITS +: 10]];
    end
endmodule

module ca_replica_nco #(
    parameter int NUM_TAPS     = 3,
    parameter int TAP_SPACING  = 2,
    parameter int SUBCHIP_BITS = 2,
    parameter int NCO_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1022:0]        CA_code,
    input  logic [NCO_WIDTH-1:0] code_fcw,
    input  logic                 cmd_valid,
    input  logic                 cmd_type,
    input  logic [15:0]          cmd_value,
    output logic                 cmd_ready,
    output logic [NUM_TAPS-1:0]  taps,
    output logic [9:0]           chip_index,
    output logic                 epoch
);
    // Two guard bits so the accumulator sum can show both carry and borrow.
    localparam int SW = NCO_WIDTH + 2;
    localparam logic [SW-1:0] U_EXT = SW'(1) << (NCO_WIDTH - SUBCHIP_BITS);
    localparam logic [9:0] LAST_CHIP = 10'd1022;

    typedef enum logic {IDLE, SLEW} state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic                  ld_pend_q, ld_pend_d;
    logic [9:0]            ld_val_q, ld_val_d;
    logic [9:0]            chip_q, chip_d;
    logic [NCO_WIDTH-1:0]  frac_q, frac_d;
    logic [NUM_TAPS-1:0]   taps_q, taps_d;
    logic                  epoch_q, epoch_d;

    logic [SW-1:0]         adj;
    logic [SW-1:0]         sum;
    logic [15:0]           slew_mag;
    logic                  accept;
    logic [NUM_TAPS-1:0]   tap_bits;

    // Magnitude of the signed slew request (0x8000 maps to 32768, fits 16 bits).
    always_comb begin
        slew_mag = cmd_value[15] ? (~cmd_value + 16'd1) : cmd_value;
    end

    // Command FSM: accepts commands in IDLE, paces slew adjustments in SLEW.
    // A load is parked for one cycle and applied on the following enabled edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        ld_pend_d = ld_pend_q;
        ld_val_d  = ld_val_q;
        adj       = '0;
        cmd_ready = (state_q == IDLE);
        accept    = cmd_valid && (state_q == IDLE);

        if (enable && ld_pend_q)
            ld_pend_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!cmd_type) begin
                        ld_pend_d = 1'b1;
                        ld_val_d  = (cmd_value >= 16'd1023) ? 10'd0 : cmd_value[9:0];
                    end else if (slew_mag != 16'd0) begin
                        cnt_d   = slew_mag;
                        dir_d   = cmd_value[15];
                        state_d = SLEW;
                    end
                end
            end
            SLEW: begin
                if (enable) begin
                    adj   = dir_q ? (~U_EXT + SW'(1)) : U_EXT;
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NCO step: carry/borrow out of frac moves the chip by one, mod 1023.
    always_comb begin
        sum     = {2'b00, frac_q} + {2'b00, code_fcw} + adj;
        chip_d  = chip_q;
        frac_d  = frac_q;
        epoch_d = 1'b0;
        if (enable) begin
            if (ld_pend_q) begin
                chip_d = ld_val_q;
                frac_d = '0;
            end else begin
                frac_d = sum[NCO_WIDTH-1:0];
                if (sum[SW-1]) begin
                    chip_d = (chip_q == 10'd0) ? LAST_CHIP : chip_q - 10'd1;
                end else if (sum[NCO_WIDTH]) begin
                    if (chip_q == LAST_CHIP) begin
                        chip_d  = 10'd0;
                        epoch_d = 1'b1;
                    end else begin
                        chip_d = chip_q + 10'd1;
                    end
                end
            end
        end
    end

    // Tap k sits ((NUM_TAPS-1)/2 - k)*TAP_SPACING sub-chips ahead of prompt.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        ca_replica_tap #(
            .SUBCHIP_BITS(SUBCHIP_BITS),
            .OFFSET      (((NUM_TAPS - 1) / 2 - k) * TAP_SPACING)
        ) u_tap (
            .chip   (chip_q),
            .sub    (frac_q[NCO_WIDTH-1 -: SUBCHIP_BITS]),
            .code   (CA_code),
            .tap_bit(tap_bits[k])
        );
    end

    // Taps are sampled from the current phase and hold while disabled.
    always_comb begin
        taps_d = enable ? tap_bits : taps_q;
    end

    // State register; reset parks everything at chip 0 with no pending work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            ld_pend_q <= 1'b0;
            ld_val_q  <= '0;
            chip_q    <= '0;
            frac_q    <= '0;
            taps_q    <= '0;
            epoch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            ld_pend_q <= ld_pend_d;
            ld_val_q  <= ld_val_d;
            chip_q    <= chip_d;
            frac_q    <= frac_d;
            taps_q    <= taps_d;
            epoch_q   <= epoch_d;
        end
    end

    assign taps       = taps_q;
    assign chip_index = chip_q;
    assign epoch      = epoch_q;
endmodule

// File: tb/tb_ca_replica_nco.sv
// Bench for ca_replica_nco: per-cycle scoreboard against a behavioural phase
// model, plus directed checks on load, tap, slew, reset and enable behaviour.
module tb_ca_replica_nco;
    localparam int NT = 3;
    localparam int TS = 2;
    localparam int SB = 2;
    localparam int NW = 32;
    localparam int MODP = 1023 << SB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [1022:0]   ca;
    logic [NW-1:0]   fcw;
    logic            cmd_valid;
    logic            cmd_type;
    logic [15:0]     cmd_value;
    logic            cmd_ready;
    logic [NT-1:0]   taps;
    logic [9:0]      chip_index;
    logic            epoch;

    ca_replica_nco #(.NUM_TAPS(NT), .TAP_SPACING(TS), .SUBCHIP_BITS(SB), .NCO_WIDTH(NW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .CA_code(ca), .code_fcw(fcw),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_value(cmd_value),
        .cmd_ready(cmd_ready), .taps(taps), .chip_index(chip_index), .epoch(epoch)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic          ready;
        logic          ep;
        logic [NT-1:0] tp;
        logic [9:0]    chip;
    } obs_t;

    obs_t sb_q[$];

    // behavioural model state
    int            m_chip;
    longint        m_frac;
    int            m_cnt;
    bit            m_slew, m_dir, m_pend, m_ep;
    int            m_pv;
    logic [NT-1:0] m_taps;

    int ncyc, ep_cnt, ep_first, ep_second;

    function automatic logic [NT-1:0] m_tapcalc();
        logic [NT-1:0] r;
        for (int k = 0; k < NT; k++) begin
            int off, p;
            off = ((NT - 1) / 2 - k) * TS;
            p = m_chip * (1 << SB) + int'(m_frac >> (NW - SB)) + off;
            p = ((p % MODP) + MODP) % MODP;
            r[k] = ca[p / (1 << SB)];
        end
        return r;
    endfunction

    task automatic m_reset();
        m_chip = 0; m_frac = 0; m_cnt = 0; m_slew = 0; m_dir = 0;
        m_pend = 0; m_ep = 0; m_pv = 0; m_taps = '0;
    endtask

    // advance the model across the next rising edge given current inputs
    task automatic model_step();
        bit            acc;
        logic [NT-1:0] nt;
        longint        s, u, full;
        int            v;
        u    = longint'(1) << (NW - SB);
        full = longint'(1) << NW;
        acc  = cmd_valid && !m_slew;
        if (enable) begin
            nt   = m_tapcalc();
            m_ep = 0;
            if (m_pend) begin
                m_chip = m_pv; m_frac = 0; m_pend = 0;
            end else begin
                s = m_frac + longint'(fcw) + (m_slew ? (m_dir ? -u : u) : 0);
                if (s >= full) begin
                    s = s - full;
                    if (m_chip == 1022) begin m_chip = 0; m_ep = 1; end
                    else m_chip = m_chip + 1;
                end else if (s < 0) begin
                    s = s + full;
                    m_chip = (m_chip == 0) ? 1022 : m_chip - 1;
                end
                m_frac = s;
            end
            m_taps = nt;
            if (m_slew) begin
                m_cnt--;
                if (m_cnt == 0) m_slew = 0;
            end
        end else begin
            m_ep = 0;
        end
        if (acc) begin
            if (!cmd_type) begin
                m_pend = 1;
                m_pv = (int'(cmd_value) >= 1023) ? 0 : int'(cmd_value);
            end else begin
                v = int'($signed(cmd_value));
                if (v != 0) begin
                    m_slew = 1; m_dir = (v < 0); m_cnt = (v < 0) ? -v : v;
                end
            end
        end
    endtask

    task automatic cyc();
        obs_t e, g;
        model_step();
        e.ready = !m_slew; e.ep = m_ep; e.tp = m_taps; e.chip = 10'(m_chip);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = {cmd_ready, epoch, taps, chip_index};
        e = sb_q.pop_front();
        chk("cyc", 64'(g), 64'(e));
        ncyc++;
        if (epoch) begin
            ep_cnt++;
            if (ep_first < 0) ep_first = ncyc;
            else if (ep_second < 0) ep_second = ncyc;
        end
    endtask

    task automatic send(input bit t, input logic [15:0] v);
        int n;
        n = 0;
        while (m_slew && n < 100) begin cyc(); n++; end
        if (n >= 100) chk("send_timeout", 64'(1), 64'(0));
        cmd_valid = 1'b1; cmd_type = t; cmd_value = v;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic rand_code();
        for (int i = 0; i < 1023; i++) ca[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int lowcnt, n, v;
        rst_n = 1'b0; enable = 1'b0; ca = '0; fcw = '0;
        cmd_valid = 1'b0; cmd_type = 1'b0; cmd_value = '0;
        ncyc = 0; ep_cnt = 0; ep_first = -1; ep_second = -1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_chip", 64'(chip_index), 64'(0));
        chk("rst_taps", 64'(taps), 64'(0));
        chk("rst_epoch", 64'(epoch), 64'(0));
        chk("rst_ready", 64'(cmd_ready), 64'(1));
        rst_n = 1'b1;

        // free-running at half a chip per cycle
        rand_code();
        fcw = 32'h8000_0000; enable = 1'b1;
        repeat (10) cyc();
        chk("run_chip10", 64'(chip_index), 64'(5));
        repeat (4090) cyc();
        chk("epoch_first", 64'(ep_first), 64'(2046));
        chk("epoch_gap", 64'(ep_second - ep_first), 64'(2046));

        // load at the boundary, then an out-of-range load
        send(1'b0, 16'd1022);
        cyc(); chk("ld1022_a", 64'(chip_index), 64'(1022));
        cyc(); chk("ld1022_b", 64'({epoch, chip_index}), 64'({1'b0, 10'd1022}));
        cyc(); chk("ld1022_wrap", 64'({epoch, chip_index}), 64'({1'b1, 10'd0}));
        cyc(); chk("ld1022_ep_once", 64'(epoch), 64'(0));
        send(1'b0, 16'd2000);
        cyc(); chk("ld2000", 64'({epoch, chip_index}), 64'(0));

        // early tap sees chip 5 from chip 4, sub 2
        ca = '0; ca[5] = 1'b1;
        send(1'b0, 16'd4);
        repeat (3) cyc();
        chk("tap_early", 64'(taps), 64'(3'b001));

        // late tap wraps backwards to chip 1022
        fcw = '0; ca = '0; ca[1022] = 1'b1;
        send(1'b0, 16'd0);
        repeat (2) cyc();
        chk("tap_wrap_late", 64'(taps), 64'(3'b100));

        // slew +8 sub-chips with a stopped NCO
        rand_code();
        send(1'b1, 16'd8);
        lowcnt = cmd_ready ? 0 : 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!cmd_ready) lowcnt++;
        end
        chk("slew_busy", 64'(lowcnt), 64'(8));
        chk("slew_chip", 64'(chip_index), 64'(2));

        // slew -4 from chip 0 wraps backwards without an epoch
        send(1'b0, 16'd0); cyc();
        ep_cnt = 0;
        send(1'b1, 16'hFFFC);
        repeat (6) cyc();
        chk("slewneg_chip", 64'(chip_index), 64'(1022));
        chk("slewneg_epoch", 64'(ep_cnt), 64'(0));

        // reset in the middle of a slew
        send(1'b0, 16'd5); cyc();
        send(1'b1, 16'd8);
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst_chip", 64'(chip_index), 64'(0));
        chk("midrst_taps", 64'(taps), 64'(0));
        chk("midrst_epoch", 64'(epoch), 64'(0));
        m_reset();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) cyc();
        chk("postrst_chip", 64'(chip_index), 64'(0));
        chk("postrst_ready", 64'(cmd_ready), 64'(1));

        // enable low in the middle of a slew
        send(1'b0, 16'd7); cyc();
        send(1'b1, 16'd8);
        repeat (2) cyc();
        enable = 1'b0;
        repeat (10) cyc();
        chk("en_hold_chip", 64'(chip_index), 64'(7));
        chk("en_hold_ready", 64'(cmd_ready), 64'(0));
        enable = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin cyc(); n++; end
        chk("en_resume_cycles", 64'(n), 64'(6));
        chk("en_final_chip", 64'(chip_index), 64'(9));

        // random mix of rates, enables and commands
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            fcw = $urandom % 32'hC000_0000;
            if ($urandom_range(0, 49) == 0) rand_code();
            if ($urandom_range(0, 5) == 0) begin
                cmd_valid = 1'b1;
                cmd_type = 1'($urandom_range(0, 1));
                if (!cmd_type) cmd_value = 16'($urandom_range(0, 1100));
                else begin
                    v = int'($urandom_range(0, 40)) - 20;
                    cmd_value = v[15:0];
                end
            end
            cyc();
            cmd_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
